// File: rtl/stap_nf_pkg.sv
// Shared widths, latency and the round/saturate helper for the STAP null former
// and its verification model.
package stap_nf_pkg;

  localparam int LATENCY = 3;

  typedef struct packed {
    logic               sat;
    logic signed [31:0] val;
  } sr_t;

  function automatic int prod_w(int dw, int cw);
    return dw + cw;
  endfunction

  function automatic int sum_w(int dw, int cw, int n);
    return dw + cw + $clog2(n);
  endfunction

  function automatic int addr_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Round half up, arithmetic shift, clip to a dout_w-bit signed range.
  function automatic sr_t sat_round(logic signed [63:0] sum, int shift, int dout_w);
    logic signed [63:0] r, hi, lo;
    sr_t o;
    r = sum;
    if (shift > 0) r = r + (64'sd1 <<< (shift - 1));
    r = r >>> shift;
    hi = (64'sd1 <<< (dout_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    o.sat = (r > hi) || (r < lo);
    o.val = (r > hi) ? hi[31:0] : (r < lo) ? lo[31:0] : r[31:0];
    return o;
  endfunction

endpackage

// File: rtl/stap_nf_coef_bank.sv
// Double-buffered coefficient banks: shadow writes, swap on accept, flat
// active-coefficient vector (index ch*NT+tap, LSBs first).
module stap_nf_coef_bank
  import stap_nf_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int NT      = 4,
  parameter int C_WIDTH = 14,
  parameter int SHIFT   = 12
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         accept,
  input  logic                         coef_we,
  input  logic [addr_w(NCH*NT)-1:0]    coef_addr,
  input  logic [C_WIDTH-1:0]           coef_data,
  input  logic                         coef_swap,
  output logic                         bank_active,
  output logic                         swap_pending,
  output logic [NCH*NT*C_WIDTH-1:0]    coef_act
);

  localparam int NC = NCH * NT;
  localparam logic [NC*C_WIDTH-1:0] BANK0_RST = {{(NC*C_WIDTH-1){1'b0}}, 1'b1} << SHIFT;

  logic [NC-1:0][C_WIDTH-1:0] bank0_q, bank0_d, bank1_q, bank1_d;
  logic bank_active_q, bank_active_d, swap_pending_q, swap_pending_d, do_swap;

  always_comb begin
    do_swap        = accept & (swap_pending_q | coef_swap);
    bank_active_d  = bank_active_q ^ do_swap;
    swap_pending_d = (swap_pending_q | coef_swap) & ~do_swap;
    bank0_d        = bank0_q;
    bank1_d        = bank1_q;
    // Target is chosen from the pre-swap bank, even when a swap lands this cycle.
    if (coef_we && (32'(coef_addr) < NC)) begin
      if (bank_active_q) bank0_d[coef_addr] = coef_data;
      else               bank1_d[coef_addr] = coef_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bank0_q        <= BANK0_RST;
      bank1_q        <= '0;
      bank_active_q  <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      bank0_q        <= bank0_d;
      bank1_q        <= bank1_d;
      bank_active_q  <= bank_active_d;
      swap_pending_q <= swap_pending_d;
    end
  end

  // The accepted sample already sees the post-swap bank.
  assign coef_act     = bank_active_d ? bank1_q : bank0_q;
  assign bank_active  = bank_active_q;
  assign swap_pending = swap_pending_q;

endmodule

// File: rtl/stap_null_former.sv
// CRPA space-time null former: NCH x NT real FIR summed, rounded and saturated.
// Optional saturation counter enabled by STAP_NULL_FORMER_SATCNT_EN.
module stap_null_former
  import stap_nf_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int NT         = 4,
  parameter int DIN_WIDTH  = 14,
  parameter int C_WIDTH    = 14,
  parameter int DOUT_WIDTH = 16,
  parameter int SHIFT      = 12
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         ce,
  input  logic                         din_valid,
  input  logic [NCH*DIN_WIDTH-1:0]     din,
  input  logic                         coef_we,
  input  logic [addr_w(NCH*NT)-1:0]    coef_addr,
  input  logic [C_WIDTH-1:0]           coef_data,
  input  logic                         coef_swap,
`ifdef STAP_NULL_FORMER_SATCNT_EN
  input  logic                         sat_cnt_clr,
  output logic [15:0]                  sat_cnt,
`endif
  output logic                         bank_active,
  output logic                         swap_pending,
  output logic                         dout_valid,
  output logic [DOUT_WIDTH-1:0]        dout,
  output logic                         dout_sat
);

  localparam int NC = NCH * NT;
  localparam int PW = prod_w(DIN_WIDTH, C_WIDTH);
  localparam int SW = sum_w(DIN_WIDTH, C_WIDTH, NC);
  localparam int DL = (NT > 1) ? NT - 1 : 1;

  logic                  accept;
  logic [NC*C_WIDTH-1:0] coef_act;

  assign accept = ce & din_valid;

  stap_nf_coef_bank #(.NCH(NCH), .NT(NT), .C_WIDTH(C_WIDTH), .SHIFT(SHIFT)) u_bank (
    .clk         (clk),
    .resetn      (resetn),
    .accept      (accept),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_swap   (coef_swap),
    .bank_active (bank_active),
    .swap_pending(swap_pending),
    .coef_act    (coef_act)
  );

  logic [NCH-1:0][NT-1:0][DIN_WIDTH-1:0] x_cur;
  logic [NCH-1:0][DL-1:0][DIN_WIDTH-1:0] dl_q, dl_d;
  logic signed [PW-1:0]         prod_q [NC];
  logic signed [PW-1:0]         prod_d [NC];
  logic signed [SW-1:0]         sum_q, sum_d;
  logic [LATENCY:1]             vld_q, vld_d;
  logic [DOUT_WIDTH-1:0]        dout_q, dout_d;
  logic                         dout_sat_q, dout_sat_d;
  sr_t                          sr;

  // Tap 0 is the live input so products register on the accept edge itself.
  always_comb begin
    dl_d = dl_q;
    for (int ch = 0; ch < NCH; ch++) begin
      x_cur[ch][0] = din[ch*DIN_WIDTH +: DIN_WIDTH];
      for (int k = 1; k < NT; k++) x_cur[ch][k] = dl_q[ch][k-1];
      if (accept)
        for (int k = 1; k < NT; k++) dl_d[ch][k-1] = x_cur[ch][k-1];
    end
    for (int ch = 0; ch < NCH; ch++)
      for (int k = 0; k < NT; k++)
        prod_d[ch*NT+k] = PW'($signed(x_cur[ch][k])) *
                          PW'($signed(coef_act[(ch*NT+k)*C_WIDTH +: C_WIDTH]));
    sum_d = '0;
    for (int i = 0; i < NC; i++) sum_d = sum_d + SW'(prod_q[i]);
    sr         = sat_round(64'(sum_q), SHIFT, DOUT_WIDTH);
    vld_d      = {vld_q[LATENCY-1:1], accept};
    dout_d     = vld_q[LATENCY-1] ? sr.val[DOUT_WIDTH-1:0] : dout_q;
    dout_sat_d = vld_q[LATENCY-1] ? sr.sat : dout_sat_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dl_q       <= '0;
      prod_q     <= '{default: '0};
      sum_q      <= '0;
      vld_q      <= '0;
      dout_q     <= '0;
      dout_sat_q <= 1'b0;
    end else begin
      dl_q <= dl_d;
      if (ce) begin
        prod_q     <= prod_d;
        sum_q      <= sum_d;
        vld_q      <= vld_d;
        dout_q     <= dout_d;
        dout_sat_q <= dout_sat_d;
      end
    end
  end

  assign dout_valid = vld_q[LATENCY];
  assign dout       = dout_q;
  assign dout_sat   = dout_sat_q;

`ifdef STAP_NULL_FORMER_SATCNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic        sat_evt;

  always_comb begin
    sat_evt   = ce & vld_q[LATENCY-1] & sr.sat;
    sat_cnt_d = sat_cnt_q;
    if (sat_cnt_clr)                          sat_cnt_d = '0;
    else if (sat_evt && sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sat_cnt_q <= '0;
    else         sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_stap_null_former.sv
// Self-checking bench for stap_null_former: scoreboard of model outputs plus a
// table of coefficient/input vectors and hand-written swap, freeze and reset sequences.
module tb_stap_null_former;

  localparam int NCH = 4, NT = 4, DW = 14, CW = 14, OW = 16, NC = 16;

  logic              clk = 1'b0, resetn = 1'b0, ce = 1'b0, din_valid = 1'b0;
  logic              coef_we = 1'b0, coef_swap = 1'b0;
  logic [NCH*DW-1:0] din = '0;
  logic [3:0]        coef_addr = '0;
  logic [CW-1:0]     coef_data = '0;
  logic              bank_active, swap_pending, dout_valid, dout_sat;
  logic [OW-1:0]     dout;
`ifdef STAP_NULL_FORMER_SATCNT_EN
  logic              sat_cnt_clr = 1'b0;
  logic [15:0]       sat_cnt;
  int                sat_exp = 0;
`endif

  stap_null_former dut (
    .clk(clk), .resetn(resetn), .ce(ce), .din_valid(din_valid), .din(din),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_swap(coef_swap),
`ifdef STAP_NULL_FORMER_SATCNT_EN
    .sat_cnt_clr(sat_cnt_clr), .sat_cnt(sat_cnt),
`endif
    .bank_active(bank_active), .swap_pending(swap_pending),
    .dout_valid(dout_valid), .dout(dout), .dout_sat(dout_sat)
  );

  always #5 clk = ~clk;

  typedef struct { int d; bit s; } exp_t;
  typedef struct { string nm; int c0, c1, call, x0, x1, x23, ed; bit es; } vec_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   vectors = 0, miscompares = 0;
  int   mb[2][NC];
  int   mdl[NCH][NT];
  bit   m_act, m_pend, last_ce;

  task automatic chk(string nm, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) for (int i = 0; i < NC; i++) mb[b][i] = 0;
    mb[0][0] = 4096;
    for (int c = 0; c < NCH; c++) for (int k = 0; k < NT; k++) mdl[c][k] = 0;
    m_act = 0; m_pend = 0;
    sbq.delete();
  endtask

  function automatic exp_t rnd(longint s);
    exp_t   e;
    longint r;
    r = (s + 2048) >>> 12;
    e.s = (r > 32767) || (r < -32768);
    e.d = (r > 32767) ? 32767 : (r < -32768) ? -32768 : int'(r);
    return e;
  endfunction

  // Advance one clock, updating the model with the inputs present at that edge.
  task automatic tick();
    bit     acc, sw, na;
    longint s;
    if (resetn) begin
      acc = ce & din_valid;
      sw  = acc & (m_pend | coef_swap);
      na  = m_act ^ sw;
      if (acc) begin
        s = 0;
        for (int c = 0; c < NCH; c++) begin
          for (int k = NT-1; k > 0; k--) mdl[c][k] = mdl[c][k-1];
          mdl[c][0] = int'($signed(din[c*DW +: DW]));
          for (int k = 0; k < NT; k++) s += longint'(mb[na][c*NT+k]) * mdl[c][k];
        end
        sbq.push_back(rnd(s));
      end
      if (coef_we) mb[!m_act][coef_addr] = int'($signed(coef_data));
      m_pend = !sw & (m_pend | coef_swap);
      m_act  = na;
    end
    last_ce = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic setx(int a, int b, int c, int d);
    din = {DW'(d), DW'(c), DW'(b), DW'(a)};
  endtask

  task automatic wr(int a, int v);
    coef_we = 1; coef_addr = 4'(a); coef_data = CW'(v);
    tick();
    coef_we = 0;
  endtask

  task automatic drain();
    din_valid = 0;
    repeat (5) tick();
  endtask

  // Scoreboard: one pop per new output (valid flags hold while ce is low).
  initial forever begin
    @(negedge clk);
    if (resetn && dout_valid && last_ce) begin
      if (sbq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_dout: got %0d with empty scoreboard", $signed(dout));
      end else begin
        mon_e = sbq.pop_front();
        chk("dout", $signed(dout), mon_e.d);
        chk("dout_sat", dout_sat, mon_e.s);
`ifdef STAP_NULL_FORMER_SATCNT_EN
        if (mon_e.s && sat_exp < 65535) sat_exp++;
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[6];
  int   lat, d0, v0, pre;

  initial begin
    tbl[0] = '{"null",      4096, -2048, 0,    100,   200,   0,     0,      0};
    tbl[1] = '{"round_pos", 2048, 0,     0,    3,     0,     0,     2,      0};
    tbl[2] = '{"round_neg", 2048, 0,     0,    -3,    0,     0,     -1,     0};
    tbl[3] = '{"sat_pos",   0,    0,     8191, 8191,  8191,  8191,  32767,  1};
    tbl[4] = '{"sat_neg",   0,    0,     8191, -8192, -8192, -8192, -32768, 1};
    tbl[5] = '{"ch1_pass",  0,    4096,  0,    55,    -777,  0,     -777,   0};

    // Reset state
    model_reset();
    #3;
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout_sat", dout_sat, 0);
    chk("rst_bank_active", bank_active, 0);
    chk("rst_swap_pending", swap_pending, 0);
    @(posedge clk); #1;
    resetn = 1;
    tick();

    // Pass-through ramp and first-output latency
    ce = 1; din_valid = 1; lat = 0;
    for (int i = 1; i <= 12; i++) begin
      setx(i, 2*i, 0, 0);
      tick();
      if (lat == 0 && dout_valid) lat = i;
    end
    chk("latency", lat, 3);
    drain();
    chk("pass_last", $signed(dout), 12);

    // Shadow write, swap held pending across idle cycles, extra pulse absorbed
    wr(4, 4096);
    coef_swap = 1; tick(); coef_swap = 0;
    chk("pend_set", swap_pending, 1);
    chk("pend_bank", bank_active, 0);
    tick(); tick();
    coef_swap = 1; tick(); coef_swap = 0;
    chk("pend_hold", swap_pending, 1);
    din_valid = 1;
    for (int i = 0; i < 6; i++) begin
      setx(5 + i, 70 + 3*i, 0, 0);
      tick();
      if (i == 0) begin
        chk("swap_bank", bank_active, 1);
        chk("swap_clear", swap_pending, 0);
      end
    end
    drain();
    chk("swap_ch1", $signed(dout), 85);
    chk("swap_bank_once", bank_active, 1);

    // ce freeze mid-stream
    din_valid = 1;
    for (int i = 0; i < 5; i++) begin setx(i, 300 + i, 0, 0); tick(); end
    ce = 0; d0 = dout; v0 = dout_valid;
    for (int i = 0; i < 5; i++) begin
      setx($urandom_range(0, 999), $urandom_range(0, 999), 0, 0);
      tick();
      chk("freeze_dout", dout, d0);
      chk("freeze_valid", dout_valid, v0);
    end
    ce = 1;
    for (int i = 0; i < 4; i++) begin setx(0, 400 + i, 0, 0); tick(); end
    drain();
    chk("unfreeze_last", $signed(dout), 403);

    // Table of coefficient sets: load shadow, swap on the first accept
    for (int t = 0; t < 6; t++) begin
      for (int a = 0; a < NC; a++)
        wr(a, (tbl[t].call != 0) ? tbl[t].call : (a == 0) ? tbl[t].c0 : (a == NT) ? tbl[t].c1 : 0);
      pre = bank_active;
      setx(tbl[t].x0, tbl[t].x1, tbl[t].x23, tbl[t].x23);
      din_valid = 1; coef_swap = 1;
      tick();
      coef_swap = 0;
      chk({tbl[t].nm, "_bank"}, bank_active, !pre);
      chk({tbl[t].nm, "_pend"}, swap_pending, 0);
      repeat (7) tick();
      drain();
      chk({tbl[t].nm, "_dout"}, $signed(dout), tbl[t].ed);
      chk({tbl[t].nm, "_sat"}, dout_sat, tbl[t].es);
    end

`ifdef STAP_NULL_FORMER_SATCNT_EN
    chk("sat_cnt", sat_cnt, sat_exp);
    sat_cnt_clr = 1; tick(); sat_cnt_clr = 0; sat_exp = 0;
    chk("sat_cnt_clr", sat_cnt, 0);
`endif

    // Reset mid-stream with samples in flight and a pending swap
    din_valid = 1;
    setx(9, 9, 9, 9); tick(); tick();
    din_valid = 0; coef_swap = 1; tick(); coef_swap = 0;
    chk("pre_rst_pend", swap_pending, 1);
    resetn = 0;
    model_reset();
    #1;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_bank", bank_active, 0);
    chk("mid_rst_pend", swap_pending, 0);
    tick(); tick();
    resetn = 1;
    tick();
    din_valid = 1;
    for (int i = 1; i <= 8; i++) begin setx(-i, 50, 0, 0); tick(); end
    drain();
    chk("post_rst_pass", $signed(dout), -8);
    chk("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
